// File: rtl/cr_clic_arb_seq.sv
// Purpose : CLIC arbiter; picks the highest-level requesting kid and presents it to the core.
// Latency : req sampled at edge t -> vld after edge t+1; at least 3 cycles per interrupt (PEND, CLAIM, IDLE).
// Backpr. : held until core_arb_int_ack. Preempted only by a strictly higher level. Withdrawn if the kid drops.
//
// Ports:
//   clic_clk, cpurst_b     clock, async active-low reset
//   kid_arb_int_req/all/hv per-kid request, level (CLICINTCTLBITS+1 bits each), hv flag
//   core_arb_int_ack       core accepts the presented interrupt
//   ctrl_arb_mintthresh    level threshold; only used when CLIC_ARB_THRESH_EN is defined
//   arb_core_int_*         presented interrupt (vld/id/level/hv), registered
//   arb_kid_claim          one-hot, one-cycle claim pulse to the accepted kid
//
// Optional feature macro: CLIC_ARB_THRESH_EN (a kid is a candidate only when level > threshold).
module cr_clic_arb_seq #(
  parameter int INT_NUM        = 16,
  parameter int ID_W           = 6,
  parameter int CLICINTCTLBITS = 3
) (
  input  logic                              clic_clk,
  input  logic                              cpurst_b,
  input  logic [INT_NUM-1:0]                kid_arb_int_req,
  input  logic [INT_NUM*(CLICINTCTLBITS+1)-1:0] kid_arb_int_all,
  input  logic [INT_NUM-1:0]                kid_arb_int_hv,
  input  logic                              core_arb_int_ack,
  input  logic [CLICINTCTLBITS:0]           ctrl_arb_mintthresh,
  output logic                              arb_core_int_vld,
  output logic [ID_W-1:0]                   arb_core_int_id,
  output logic [CLICINTCTLBITS:0]           arb_core_int_level,
  output logic                              arb_core_int_hv,
  output logic [INT_NUM-1:0]                arb_kid_claim
);

  localparam int LW = CLICINTCTLBITS + 1;

  typedef enum logic [1:0] {IDLE, PEND, CLAIM} state_t;

  state_t             state, state_nxt;
  logic               vld_nxt;
  logic [ID_W-1:0]    id_nxt;
  logic [LW-1:0]      level_nxt;
  logic               hv_nxt;
  logic [INT_NUM-1:0] claim_nxt;

  logic [INT_NUM-1:0] cand;
  logic               win_any;
  logic [ID_W-1:0]    win_id;
  logic [LW-1:0]      win_level;
  logic               win_hv;
  logic               held_req;
  logic               drop;

`ifdef CLIC_ARB_THRESH_EN
  always_comb begin
    cand = '0;
    for (int i = 0; i < INT_NUM; i++) begin
      cand[i] = kid_arb_int_req[i] && (kid_arb_int_all[i*LW +: LW] > ctrl_arb_mintthresh);
    end
  end
  // A raised threshold retracts the presented interrupt like a dropped request.
  assign drop = !held_req || (arb_core_int_level <= ctrl_arb_mintthresh);
`else
  logic unused_thresh;
  assign unused_thresh = ^ctrl_arb_mintthresh;
  assign cand = kid_arb_int_req;
  assign drop = !held_req;
`endif

  // Linear max-scan; '>=' lets a later (higher) ID win ties. The win_any flag
  // keeps level-0 candidates eligible.
  always_comb begin
    win_any   = 1'b0;
    win_id    = '0;
    win_level = '0;
    win_hv    = 1'b0;
    held_req  = 1'b0;
    for (int i = 0; i < INT_NUM; i++) begin
      if (cand[i] && (!win_any || kid_arb_int_all[i*LW +: LW] >= win_level)) begin
        win_any   = 1'b1;
        win_id    = ID_W'(i);
        win_level = kid_arb_int_all[i*LW +: LW];
        win_hv    = kid_arb_int_hv[i];
      end
      if (ID_W'(i) == arb_core_int_id) begin
        held_req = kid_arb_int_req[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    vld_nxt   = arb_core_int_vld;
    id_nxt    = arb_core_int_id;
    level_nxt = arb_core_int_level;
    hv_nxt    = arb_core_int_hv;
    claim_nxt = '0;
    case (state)
      IDLE: begin
        if (win_any) begin
          vld_nxt   = 1'b1;
          id_nxt    = win_id;
          level_nxt = win_level;
          hv_nxt    = win_hv;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (core_arb_int_ack) begin
          // Ack claims what is on the outputs now, not a same-cycle preemptor.
          vld_nxt   = 1'b0;
          state_nxt = CLAIM;
          for (int i = 0; i < INT_NUM; i++) begin
            claim_nxt[i] = (ID_W'(i) == arb_core_int_id);
          end
        end else if (drop) begin
          vld_nxt   = 1'b0;
          state_nxt = IDLE;
        end else if (win_any && (win_level > arb_core_int_level)) begin
          id_nxt    = win_id;
          level_nxt = win_level;
          hv_nxt    = win_hv;
        end
      end
      CLAIM: begin
        // Dead cycle so the claimed kid can clear its pending bit.
        state_nxt = IDLE;
      end
      default: begin
        vld_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clic_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state              <= IDLE;
      arb_core_int_vld   <= 1'b0;
      arb_core_int_id    <= '0;
      arb_core_int_level <= '0;
      arb_core_int_hv    <= 1'b0;
      arb_kid_claim      <= '0;
    end else begin
      state              <= state_nxt;
      arb_core_int_vld   <= vld_nxt;
      arb_core_int_id    <= id_nxt;
      arb_core_int_level <= level_nxt;
      arb_core_int_hv    <= hv_nxt;
      arb_kid_claim      <= claim_nxt;
    end
  end

endmodule

// File: doc/cr_clic_arb_seq.md
Name: cr_clic_arb_seq

Overview:
- Arbitration end of the CLIC kid-to-arbiter interface. Collects per-interrupt request, level and hardware-vector (hv) outputs from INT_NUM kid slices and selects the highest-level pending interrupt.
- Presents the winner to the core through a registered valid/ack handshake. On ack, returns a one-hot claim pulse to the winning kid.
- Sits between the kid array and the core interrupt interface inside the CLIC top.

Parameters:
- INT_NUM, 16, number of kid slices (2..64).
- ID_W, 6, interrupt ID width; must satisfy 2^ID_W >= INT_NUM.
- CLICINTCTLBITS, 3, level bits per kid. Level field width is CLICINTCTLBITS+1.

Ports:
- clic_clk  in  1  block clock.
- cpurst_b  in  1  asynchronous active-low reset.
- kid_arb_int_req  in  INT_NUM  per-kid request; qualified (enabled and pending).
- kid_arb_int_all  in  INT_NUM*(CLICINTCTLBITS+1)  per-kid level. Kid i occupies bits [i*(CLICINTCTLBITS+1) +: CLICINTCTLBITS+1].
- kid_arb_int_hv  in  INT_NUM  per-kid hardware-vector flag.
- core_arb_int_ack  in  1  core accepts the presented interrupt.
- ctrl_arb_mintthresh  in  CLICINTCTLBITS+1  level threshold (see Optional Feature).
- arb_core_int_vld  out  1  interrupt presented.
- arb_core_int_id  out  ID_W  winner ID.
- arb_core_int_level  out  CLICINTCTLBITS+1  winner level.
- arb_core_int_hv  out  1  winner hv flag.
- arb_kid_claim  out  INT_NUM  one-hot claim pulse to the winning kid.

Behaviour:
- Reset (cpurst_b low, asynchronous): all outputs 0; FSM to IDLE. Reset mid-handshake drops vld immediately; no claim is issued.
- Combinational selection each cycle:
  - Candidate kids have req=1.
  - Winner has the maximum level.
  - Ties go to the highest ID.
  - A candidate with level 0 is still eligible.
- FSM states IDLE, PEND, CLAIM:
  - IDLE: if any candidate exists, register winner id/level/hv, set vld=1, go to PEND. Latency: req rising at edge t gives vld=1 after edge t+1.
  - PEND, ack=1: drop vld, pulse arb_kid_claim[id] for exactly one cycle, go to CLAIM. Ack applies to the values currently presented, even if a new winner appears in the same cycle.
  - PEND, ack=0, presented kid's req dropped: withdraw (vld=0), go to IDLE. No claim is issued.
  - PEND, ack=0, otherwise: if the current winner's level is strictly greater than the held level, replace id/level/hv in place. vld stays 1.
    - Equal level does not replace, even with a higher ID, to keep the outputs stable.
  - CLAIM: one cycle with vld=0, which gives the kid time to clear its pending bit. Then go to IDLE.
- While vld=1, id/level/hv change only through the preemption rule above.
- ack while vld=0 is ignored.
- arb_kid_claim is 0 outside the CLAIM entry cycle.
- An ID >= INT_NUM is never output.
- Back-to-back interrupts: minimum 3 cycles per interrupt (PEND, CLAIM, IDLE re-arbitration).

Optional Feature:
- Macro: CLIC_ARB_THRESH_EN.
- Defined: a kid is a candidate only if req=1 and level > ctrl_arb_mintthresh (strict).
  - In PEND, if the held level is no longer above the threshold (threshold raised), withdraw to IDLE as for a dropped request.
- Undefined: ctrl_arb_mintthresh is ignored, with no logic attached. All requesting kids are candidates.

Test Plan:
- Single request, kid 5 level 3, hv=1, ack two cycles after vld → vld=1 one cycle after req, id=5, level=3, hv=1. Then claim=1<<5 for one cycle, vld=0 for one cycle, then IDLE.
- Kids 2 and 9 both at level 4 → id=9. Kids 2 (level 6) and 9 (level 4) → id=2.
- In PEND with kid 3 at level 2, kid 7 rises at level 5 with no ack → id updates to 7 the next cycle with vld held 1. Kid 8 then rises at level 5 → no change.
- Kid 4 presented, its req drops before ack → vld falls the next cycle, claim stays 0. Ack in the same cycle kid 10 preempts → claim targets the presented kid 4.
- cpurst_b asserted during PEND → vld, id, claim all 0 immediately. After release with req still high → re-presented one cycle later.
- CLIC_ARB_THRESH_EN defined, threshold 3, kid 1 at level 3 → never presented. Level 4 → presented. Threshold raised to 4 in PEND → withdrawn.
